controlador_display: RTL
========================

Name: controlador_display

Overview:
- Sequential controller that owns the shared seven-segment bus on the Basys3 board.
- Accepts a binary value through a valid/ready handshake and converts it to two BCD digits with an iterative shift-add-3 (double dabble) engine.
- Commits both digits to display registers in a single cycle, then time-multiplexes them onto the segment/anode lines.
- Sits downstream of Gray_a_Binario and replaces the combinational digit-select logic in siete_segmentos.

Parameters:
- WIDTH, 4, bit width of the binary input; legal range 1..6 (max value 63 fits two digits).
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- bin  input  WIDTH  binary value to display.
- in_valid  input  1  bin is valid this cycle.
- in_ready  output  1  controller can accept a value (IDLE state).
- conv_done  output  1  one-cycle pulse when new digits are committed.
- seg  output  7  segments a..g, a = MSB, active-low (cero = 7'b000_0001).
- anodos  output  4  digit enables, active-low; [0] = unidades, [1] = decenas, [3:2] always 1.

Behaviour:
- Clock and reset: one clock domain; reset is asynchronous and active-low.
- Reset values: state IDLE; in_ready 1; conv_done 0; seg 7'b111_1111; anodos 4'b1111; display registers 0; prescaler 0; digit select 0.
- FSM states: IDLE, CONV, COMMIT.
  - IDLE: in_ready=1. When in_valid && in_ready, capture bin into the shift register, clear the BCD accumulator, load the iteration counter with WIDTH, go to CONV.
  - CONV: in_ready=0. Each cycle, add 3 to every BCD nibble ≥5, then shift {bcd, shift} left by 1 and decrement the counter. After WIDTH iterations, go to COMMIT.
  - COMMIT: copy the accumulator into the unidades/decenas registers in the same edge, pulse conv_done=1 for one cycle, return to IDLE.
- Latency: handshake accepted at cycle 0; conv_done high in cycle WIDTH+1; new value accepted again from cycle WIDTH+2.
- Handshake rules:
  - in_valid while in_ready=0 is ignored; no queueing.
  - bin changes after capture have no effect on the conversion in progress.
- Display registers change only in COMMIT, so the scan never shows a half-converted value.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1 and wraps; tick is asserted when it equals REFRESH_DIV-1.
  - On tick, digit select toggles 0↔1.
  - REFRESH_DIV=1 toggles every cycle.
- Outputs are registered from digit select:
  - sel=0 → anodos 4'b1110, seg = code(unidades).
  - sel=1 → anodos 4'b1101, seg = code(decenas).
  - Outputs update on the edge after the select change.
- Segment codes: 0..9 per the team encoding table. Any nibble >9 (unreachable) → 7'b111_1111.
- Scan runs independently of the FSM; a commit takes effect on the next registered output update.
- Reset asserted mid-conversion: the conversion is aborted immediately (async) and all state returns to reset values. After release the display shows 00 (or blanked per the optional feature) until the next commit.

Optional Feature:
- Macro: BLANCO_CEROS_EN.
- Defined: leading-zero blanking. When decenas==0 and sel=1, anodos=4'b1111 and seg=7'b111_1111; the scan timing is unchanged.
- Undefined: decenas are always displayed, including a leading 0.

Test Plan:
- Reset: hold rst_n=0 across 3 edges, then release → anodos=1111, seg=1111111 during reset; in_ready=1 on the first edge after release; first tick shows 00 (without macro).
- Conversion: WIDTH=4, bin=13 with in_valid pulsed at cycle 0 → conv_done at cycle 5. sel=0 → seg=0000110, anodos=1110; sel=1 → seg=1001111, anodos=1101.
- Scan timing: REFRESH_DIV=4 → anodos alternates 1110/1101, each held exactly 4 cycles; [3:2] never 0.
- Busy: bin=9 accepted, then in_valid with bin=2 at cycles 1-3 → ignored; display commits 09 only, one conv_done pulse.
- Reset mid-CONV: assert rst_n=0 at cycle 2 of converting 15 → outputs go to reset values immediately; after release the display shows 00 and no conv_done is produced.
- BLANCO_CEROS_EN: bin=7 → units slot seg=0001111; tens slot anodos=1111, seg=1111111. With bin=10 both digits are shown.

Source files
------------

// File: rtl/controlador_display.sv
// Seven-segment controller: valid/ready capture, double-dabble binary-to-BCD, two-digit scan.
// Optional leading-zero blanking of the tens digit when BLANCO_CEROS_EN is defined.
module controlador_display #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] bin,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             conv_done,
  output logic [6:0]       seg,
  output logic [3:0]       anodos
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shift_q, shift_nx;
  logic [7:0]       bcd_q, bcd_nx, adj_c;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic [3:0]       unidades, decenas;
  logic [PRE_W-1:0] pre;
  logic             sel;
  logic             tick_c;
  logic [3:0]       digit_c;
  logic [3:0]       anodos_nx;
  logic [6:0]       seg_nx;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b000_0001;
      4'd1:    seg_code = 7'b100_1111;
      4'd2:    seg_code = 7'b001_0010;
      4'd3:    seg_code = 7'b000_0110;
      4'd4:    seg_code = 7'b100_1100;
      4'd5:    seg_code = 7'b010_0100;
      4'd6:    seg_code = 7'b010_0000;
      4'd7:    seg_code = 7'b000_1111;
      4'd8:    seg_code = 7'b000_0000;
      4'd9:    seg_code = 7'b000_0100;
      default: seg_code = 7'b111_1111;
    endcase
  endfunction

  // State and datapath registers; handshake outputs follow the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_q   <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      in_ready  <= 1'b1;
      conv_done <= 1'b0;
      unidades  <= '0;
      decenas   <= '0;
    end else begin
      state     <= state_nx;
      shift_q   <= shift_nx;
      bcd_q     <= bcd_nx;
      cnt_q     <= cnt_nx;
      in_ready  <= (state_nx == IDLE);
      conv_done <= (state_nx == COMMIT);
      if (state == COMMIT) begin
        unidades <= bcd_q[3:0];
        decenas  <= bcd_q[7:4];
      end
    end
  end

  // Next-state and one double-dabble iteration per CONV cycle.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift_q;
    bcd_nx     = bcd_q;
    cnt_nx     = cnt_q;
    adj_c[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj_c[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          shift_nx = bin;
          bcd_nx   = '0;
          cnt_nx   = CNT_W'(WIDTH);
          state_nx = CONV;
        end
      end
      CONV: begin
        {bcd_nx, shift_nx} = {adj_c, shift_q} << 1;
        cnt_nx = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_nx = COMMIT;
      end
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Free-running scan prescaler and digit select.
  assign tick_c = (pre == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
      sel <= 1'b0;
    end else begin
      pre <= tick_c ? '0 : pre + PRE_W'(1);
      if (tick_c) sel <= ~sel;
    end
  end

  assign digit_c = sel ? decenas : unidades;

  always_comb begin
    anodos_nx = sel ? 4'b1101 : 4'b1110;
    seg_nx    = seg_code(digit_c);
`ifdef BLANCO_CEROS_EN
    if (sel && (decenas == 4'd0)) begin
      anodos_nx = 4'b1111;
      seg_nx    = 7'b111_1111;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anodos <= 4'b1111;
      seg    <= 7'b111_1111;
    end else begin
      anodos <= anodos_nx;
      seg    <= seg_nx;
    end
  end

endmodule
